// File: rtl/cpu_hazard_scoreboard.sv
// cpu_hazard_scoreboard
//   Load-use hazard scoreboard for the ID stage. Each architectural register
//   has a pending bit that marks it as the target of a variable-latency load
//   still in flight. ID is stalled when it reads a pending register (RAW) or
//   when it tries to issue another writing load while MAX_PEND are already
//   outstanding (capacity).
//
//   Optional feature: define CPU_HAZARD_PERF_EN to add the stall_cycles
//   performance counter and the stall FSM that drives it.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   id_valid             ID holds an instruction attempting issue
//   ra_id/rb_id          source register indices; ra_used/rb_used qualify them
//   rd_id, writeback_id  destination index and its write enable
//   is_load_id           ID instruction is a variable-latency load
//   flush                squashes the ID instruction this cycle
//   load_done, load_rd   a load result reaches WB for register load_rd
//   stall                hold ID/IF
//   stall_reason         00 none, 01 RAW on pending load, 10 load capacity full
//   stall_cycles         saturating count of stalled cycles (perf build only)
module cpu_hazard_scoreboard #(
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_PEND   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] ra_id,
  input  logic [REG_ADDR_W-1:0] rb_id,
  input  logic                  ra_used,
  input  logic                  rb_used,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  writeback_id,
  input  logic                  is_load_id,
  input  logic                  flush,
  input  logic                  load_done,
  input  logic [REG_ADDR_W-1:0] load_rd,
  output logic                  stall,
  output logic [1:0]            stall_reason
`ifdef CPU_HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  logic [REG_COUNT-1:0] pending, pending_nxt;
  logic [3:0]           pend_cnt, pend_cnt_nxt;

  logic raw, cap, issue, set_en, clr_en;

  // Hazards look only at registered state: a load_done in the same cycle
  // does not release the dependent instruction until the following cycle.
  always_comb begin
    raw   = (ra_used && pending[ra_id]) || (rb_used && pending[rb_id]);
    cap   = id_valid && is_load_id && writeback_id && (pend_cnt == 4'(MAX_PEND));
    stall = id_valid && !flush && (raw || cap);
    if (!stall)   stall_reason = 2'b00;
    else if (raw) stall_reason = 2'b01;
    else          stall_reason = 2'b10;
  end

  // r0 is hardwired zero, so loads to it are never tracked. A completion with
  // nothing outstanding (e.g. a load discarded by reset) is dropped.
  always_comb begin
    issue  = id_valid && !stall && !flush;
    set_en = issue && is_load_id && writeback_id && (rd_id != '0);
    clr_en = load_done && (load_rd != '0) && (pend_cnt != 4'd0);
  end

  // Clear first, then set, so a same-register collision leaves the bit set.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[load_rd] = 1'b0;
    if (set_en) pending_nxt[rd_id]   = 1'b1;
    case ({set_en, clr_en})
      2'b10:   pend_cnt_nxt = pend_cnt + 4'd1;
      2'b01:   pend_cnt_nxt = pend_cnt - 4'd1;
      default: pend_cnt_nxt = pend_cnt;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending  <= '0;
      pend_cnt <= 4'd0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= pend_cnt_nxt;
    end
  end

`ifdef CPU_HAZARD_PERF_EN
  typedef enum logic {RUN, STALLED} st_t;
  st_t  st_q, st_d;
  logic cyc_inc;

  always_ff @(posedge clock) begin
    if (reset) st_q <= RUN;
    else       st_q <= st_d;
  end

  // Entering STALLED counts the first stalled cycle; each further stalled
  // cycle in STALLED counts as well.
  always_comb begin
    st_d    = st_q;
    cyc_inc = 1'b0;
    case (st_q)
      RUN: if (stall) begin
        st_d    = STALLED;
        cyc_inc = 1'b1;
      end
      STALLED: if (stall) cyc_inc = 1'b1;
               else       st_d    = RUN;
      default: st_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)                             stall_cycles <= '0;
    else if (cyc_inc && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cpu_hazard_scoreboard.sv
// Directed bench for cpu_hazard_scoreboard: hand-computed expectations for
// load-use stalls, capacity stalls, set/clear collisions, r0 handling and
// reset discard. Inputs change 1 time unit after the rising edge and outputs
// are sampled a further unit later, away from the edge.
module tb_cpu_hazard_scoreboard;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_valid, ra_used, rb_used, writeback_id, is_load_id, flush, load_done;
  logic [4:0] ra_id, rb_id, rd_id, load_rd;
  logic       stall;
  logic [1:0] stall_reason;
`ifdef CPU_HAZARD_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  cpu_hazard_scoreboard #(.REG_COUNT(32), .REG_ADDR_W(5), .MAX_PEND(4)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .ra_id(ra_id), .rb_id(rb_id), .ra_used(ra_used), .rb_used(rb_used),
    .rd_id(rd_id), .writeback_id(writeback_id), .is_load_id(is_load_id),
    .flush(flush), .load_done(load_done), .load_rd(load_rd),
    .stall(stall), .stall_reason(stall_reason)
`ifdef CPU_HAZARD_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; ra_used = 0; rb_used = 0; writeback_id = 0; is_load_id = 0;
    flush = 0; load_done = 0; ra_id = 0; rb_id = 0; rd_id = 0; load_rd = 0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic ld(input logic [4:0] rd);
    idle(); id_valid = 1; is_load_id = 1; writeback_id = 1; rd_id = rd;
  endtask

  task automatic done(input logic [4:0] rd);
    idle(); load_done = 1; load_rd = rd;
  endtask

  initial begin
    idle(); reset = 1;
    tick(); tick();
    reset = 0;

    // reset state, arbitrary reads see nothing pending
    id_valid = 1; ra_used = 1; ra_id = 5; rb_used = 1; rb_id = 31; is_load_id = 1; writeback_id = 1;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_reason", stall_reason, 0);
    chk("rst_cnt", dut.pend_cnt, 0);
    chk("rst_pend", dut.pending, 0);
`ifdef CPU_HAZARD_PERF_EN
    chk("rst_perf", stall_cycles, 0);
`endif
    idle(); tick();

    // load r5 then use r5
    ld(5); #1; chk("ld5_stall", stall, 0); tick();
    idle(); id_valid = 1; ra_id = 5; ra_used = 1; #1;
    chk("use5_stall", stall, 1);
    chk("use5_reason", stall_reason, 1);
    chk("use5_p5", dut.pending[5], 1);
    chk("use5_cnt", dut.pend_cnt, 1);
    tick();
`ifdef CPU_HAZARD_PERF_EN
    chk("perf_1", stall_cycles, 1);
`endif
    load_done = 1; load_rd = 5; #1;
    chk("done5_same_stall", stall, 1);
    tick();
    load_done = 0; #1;
    chk("after5_stall", stall, 0);
    chk("after5_reason", stall_reason, 0);
    chk("after5_p5", dut.pending[5], 0);
    chk("after5_cnt", dut.pend_cnt, 0);
    tick();

    // rb path, unused operand and flush masking
    ld(9); tick();
    idle(); id_valid = 1; ra_id = 9; rb_id = 9; rb_used = 1; #1;
    chk("rb9_stall", stall, 1);
    chk("rb9_reason", stall_reason, 1);
    rb_used = 0; #1;
    chk("unused9_stall", stall, 0);
    rb_used = 1; flush = 1; #1;
    chk("flush_stall", stall, 0);
    done(9); tick();
    chk("done9_cnt", dut.pend_cnt, 0);

    // capacity: four loads fill the table
    for (int i = 1; i <= 4; i++) begin
      ld(5'(i)); #1; chk("fill_stall", stall, 0); tick();
    end
    chk("full_cnt", dut.pend_cnt, 4);
    ld(6); #1;
    chk("cap_stall", stall, 1);
    chk("cap_reason", stall_reason, 2);
    ra_id = 1; ra_used = 1; #1;
    chk("cap_raw_reason", stall_reason, 1);
    ra_used = 0; is_load_id = 0; #1;
    chk("cap_nonload", stall, 0);
    is_load_id = 1; writeback_id = 0; #1;
    chk("cap_nowb", stall, 0);
    writeback_id = 1; load_done = 1; load_rd = 1; #1;
    chk("cap_done_same", stall, 1);
    tick();
    chk("cap_p1", dut.pending[1], 0);
    chk("cap_cnt3", dut.pend_cnt, 3);
    load_done = 0; #1;
    chk("cap_release", stall, 0);
    tick();
    chk("cap_p6", dut.pending[6], 1);
    chk("cap_cnt4", dut.pend_cnt, 4);

    // drain r2..r4, then collisions
    done(2); tick(); done(3); tick(); done(4); tick();
    chk("drain_cnt", dut.pend_cnt, 1);
    ld(7); tick();
    chk("ld7_cnt", dut.pend_cnt, 2);
    ld(7); load_done = 1; load_rd = 7; tick();
    chk("same_p7", dut.pending[7], 1);
    chk("same_cnt", dut.pend_cnt, 2);
    ld(8); load_done = 1; load_rd = 6; tick();
    chk("diff_p6", dut.pending[6], 0);
    chk("diff_p8", dut.pending[8], 1);
    chk("diff_cnt", dut.pend_cnt, 2);
    done(7); tick(); done(8); tick();
    chk("empty_cnt", dut.pend_cnt, 0);

    // r0 loads are not tracked; spurious completions ignored
    ld(0); tick();
    chk("r0_cnt", dut.pend_cnt, 0);
    chk("r0_pend", dut.pending, 0);
    idle(); id_valid = 1; ra_id = 0; ra_used = 1; #1;
    chk("r0_read_stall", stall, 0);
    tick();
    done(3); tick();
    chk("spur_cnt", dut.pend_cnt, 0);
    chk("spur_pend", dut.pending, 0);

    // non-load writer does not clear an older pending load
    ld(10); tick();
    idle(); id_valid = 1; rd_id = 10; writeback_id = 1; tick();
    chk("waw_p10", dut.pending[10], 1);
    chk("waw_cnt", dut.pend_cnt, 1);

    // reset discards three loads in flight
    ld(11); tick(); ld(12); tick();
    chk("three_cnt", dut.pend_cnt, 3);
    idle(); reset = 1; tick(); reset = 0;
    chk("rst2_pend", dut.pending, 0);
    chk("rst2_cnt", dut.pend_cnt, 0);
    id_valid = 1; ra_id = 10; ra_used = 1; #1;
    chk("rst2_stall", stall, 0);
`ifdef CPU_HAZARD_PERF_EN
    chk("rst2_perf", stall_cycles, 0);
`endif
    done(10); tick();
    chk("rst2_late_done", dut.pend_cnt, 0);

    // three-cycle RAW stall
    ld(13); tick();
    idle(); id_valid = 1; rb_id = 13; rb_used = 1; #1;
    chk("raw3_c1", stall, 1); tick();
    chk("raw3_c2", stall, 1); tick();
    load_done = 1; load_rd = 13; #1;
    chk("raw3_c3", stall, 1); tick();
    load_done = 0; #1;
    chk("raw3_c4", stall, 0);
`ifdef CPU_HAZARD_PERF_EN
    chk("raw3_perf", stall_cycles, 3);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
